sprite_mask_engine: RTL and testbench
=====================================

// Module: sprite_mask_engine
// PURPOSE
//   Multi-sprite, parametrised successor to the fixed 16x16 1-bit sprite mask ROM.
//   Holds N writable 1-bit masks, each with its own screen position, enable and flip mode.
//   Tests each incoming VGA pixel coordinate against all sprites through a 2-stage pipeline.
//   Returns hit, winning sprite id and mask bit to the colour mixer; sits between the VGA
//   timing counter and the pixel colour mux.
// PARAMETERS
//   SPR_W    16  sprite width in pixels (power of 2)
//   SPR_H    16  sprite height in pixels (power of 2)
//   N_SPR    4   number of sprites (1..8)
//   COORD_W  10  width of screen X/Y coordinates
//   Derived: AW = log2(SPR_W*SPR_H), IW = max(1, log2(N_SPR)).
// PORTS
//   Clock        in   1        system clock, all logic on rising edge
//   Reset        in   1        asynchronous, active-low reset
//   oReady       out  1        1 = clear sweep done, engine in RUN
//   iWrEn        in   1        mask write strobe
//   iWrSprite    in   IW       sprite selected for the mask write
//   iWrAddr      in   AW       mask address {row,col}; row = MSBs
//   iWrData      in   1        mask bit to write
//   iPosEn       in   1        position/mode load strobe
//   iPosSprite   in   IW       sprite selected for the position load
//   iPosX,iPosY  in   COORD_W  top-left corner of the sprite
//   iPosFlip     in   2        {flipY, flipX} mode loaded with the position
//   iSprEnable   in   N_SPR    per-sprite display enable (level, sampled in stage 1)
//   iPixelX/Y    in   COORD_W  coordinate of the pixel being drawn
//   iPixelValid  in   1        coordinate valid this cycle
//   oValid       out  1        result valid (iPixelValid delayed 2 cycles)
//   oHit         out  1        some enabled sprite has mask=1 at this pixel
//   oSprId       out  IW       lowest-index sprite with mask=1; 0 when oHit=0
// BEHAVIOUR
//   Reset: oReady=0, oValid=0, oHit=0, oSprId=0, all positions=0, flips=0, FSM->CLEAR.
//     Pipeline registers are cleared.
//   FSM CLEAR: internal counter walks all N_SPR*SPR_H*SPR_W mask bits, writing 0, one per cycle.
//     External writes and position loads are ignored in CLEAR.
//     iPixelValid is ignored in CLEAR (oValid stays 0).
//   FSM CLEAR->RUN: occurs on the cycle after the last address is cleared.
//     oReady rises with entry to RUN; RUN holds until Reset.
//   Mask write (RUN, iWrEn=1): bit committed at the clock edge; visible to pixels that
//     reach stage 2 on a later edge.
//     Same-cycle read of the same bit returns the OLD value (read-before-write).
//   Position load (RUN, iPosEn=1): X, Y and flip for iPosSprite are updated at the edge;
//     the new values apply to pixels entering stage 1 on the next cycle.
//     Writes and loads to a sprite index >= N_SPR are discarded.
//   Stage 1 (per sprite s): dx = iPixelX - posX[s] and dy = iPixelY - posY[s], unsigned,
//     each COORD_W+1 bits so no wrap.
//     inBox[s] = enable[s] & (iPixelX >= posX[s]) & (dx < SPR_W)
//                & (iPixelY >= posY[s]) & (dy < SPR_H).
//     col = flipX ? SPR_W-1-dx : dx; row = flipY ? SPR_H-1-dy : dy.
//     Registered: inBox, {row,col}, valid.
//   Stage 2: maskBit[s] = mem[s][addr] & inBox[s].
//     Fixed priority, lowest index wins.
//     oHit, oSprId and oValid are registered outputs.
//   Latency: exactly 2 cycles from iPixelValid to oValid; throughput 1 pixel per cycle.
//   Boundary cases:
//     Sprite partially off-screen (posX > 2^COORD_W - SPR_W): only on-screen pixels are
//       tested; no wrap to X=0.
//     Overlapping sprites: lower index wins.
//     iPixelValid=0: oValid=0 two cycles later; oHit and oSprId are forced to 0.
//   Reset asserted mid-operation: all in-flight pixels are dropped; FSM re-enters CLEAR and
//     all masks are re-zeroed.
// TESTING
//   1. Reset, then idle: oReady=0 for exactly N_SPR*SPR_W*SPR_H cycles (1024 at defaults),
//      then 1. A pixel sweep with all sprites enabled -> oHit=0 everywhere.
//   2. Write sprite0 mask = corner pattern (rows 0-2 and 13-15, cols 0-2 and 13-15 set);
//      pos=(100,50), enable=0001. Pixel (100,50) -> oHit=1, oSprId=0, 2 cycles later;
//      (103,50) -> 0; (116,50) -> 0; (99,50) -> 0.
//   3. Sprites 0 and 2 both full-mask at (10,10); pixel (12,12) -> oSprId=0.
//      Disable sprite 0 -> oSprId=2.
//   4. Sprite1 single bit at row 0, col 0; flip=2'b01; pos (0,0).
//      Pixel (15,0) -> hit; pixel (0,0) -> no hit. flip=2'b11: pixel (15,15) -> hit.
//   5. Sprite at (1020,0): pixel (1023,0) hits col 3; pixel (0,0) -> no hit.
//      Same-cycle write of 0 to the bit being read -> old value 1 returned; next pixel -> 0.
//   6. Pull Reset low while the pipeline is full and write strobes are active:
//      oValid=0 immediately; after release, oReady=0 for 1024 cycles and all masks read 0.

Source files
------------

// File: rtl/sprite_mask_engine_if.sv
// Bus bundle between the VGA front end / mask loader and the sprite mask engine.
// The engine takes the slave view; the driving logic takes the master view.
interface sprite_mask_engine_if #(
   parameter int SPR_W   = 16,
   parameter int SPR_H   = 16,
   parameter int N_SPR   = 4,
   parameter int COORD_W = 10
);
   localparam int AW = $clog2(SPR_W * SPR_H);
   localparam int IW = (N_SPR > 1) ? $clog2(N_SPR) : 1;

   logic                oReady;
   logic                iWrEn;
   logic [IW-1:0]       iWrSprite;
   logic [AW-1:0]       iWrAddr;
   logic                iWrData;
   logic                iPosEn;
   logic [IW-1:0]       iPosSprite;
   logic [COORD_W-1:0]  iPosX;
   logic [COORD_W-1:0]  iPosY;
   logic [1:0]          iPosFlip;
   logic [N_SPR-1:0]    iSprEnable;
   logic [COORD_W-1:0]  iPixelX;
   logic [COORD_W-1:0]  iPixelY;
   logic                iPixelValid;
   logic                oValid;
   logic                oHit;
   logic [IW-1:0]       oSprId;

   modport slave (
      output oReady, oValid, oHit, oSprId,
      input  iWrEn, iWrSprite, iWrAddr, iWrData,
      input  iPosEn, iPosSprite, iPosX, iPosY, iPosFlip,
      input  iSprEnable, iPixelX, iPixelY, iPixelValid
   );

   modport master (
      input  oReady, oValid, oHit, oSprId,
      output iWrEn, iWrSprite, iWrAddr, iWrData,
      output iPosEn, iPosSprite, iPosX, iPosY, iPosFlip,
      output iSprEnable, iPixelX, iPixelY, iPixelValid
   );
endinterface

// File: rtl/sprite_mask_engine.sv
// Multi-sprite 1-bit mask engine. After reset every mask bit is swept to zero,
// then each pixel coordinate is tested against all sprites in a 2-stage pipeline:
// stage 1 does the box test and flip addressing, stage 2 reads the masks and
// resolves the lowest-index hit.
module sprite_mask_engine #(
   parameter int SPR_W   = 16,
   parameter int SPR_H   = 16,
   parameter int N_SPR   = 4,
   parameter int COORD_W = 10
) (
   input  logic                 Clock,
   input  logic                 Reset,
   sprite_mask_engine_if.slave  bus
);
   localparam int CB = $clog2(SPR_W);
   localparam int RB = $clog2(SPR_H);
   localparam int AW = CB + RB;
   localparam int IW = (N_SPR > 1) ? $clog2(N_SPR) : 1;
   localparam int DW = COORD_W + 1;
   localparam int MW = SPR_W * SPR_H;

   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic                w_clr_active;
   logic                w_run;
   logic                w_clr_last;
   logic [IW-1:0]       r_clr_spr;
   logic [AW-1:0]       r_clr_addr;
   logic                r_ready;

   logic                w_wr_ok;
   logic                w_pos_ok;
   logic                w_mem_we;
   logic [IW-1:0]       w_mem_spr;
   logic [AW-1:0]       w_mem_addr;
   logic                w_mem_wd;
   logic [MW-1:0]       r_mem [N_SPR];

   logic [COORD_W-1:0]  r_pos_x [N_SPR];
   logic [COORD_W-1:0]  r_pos_y [N_SPR];
   logic [1:0]          r_flip  [N_SPR];

   logic [DW-1:0]       w_dx    [N_SPR];
   logic [DW-1:0]       w_dy    [N_SPR];
   logic [CB-1:0]       w_col   [N_SPR];
   logic [RB-1:0]       w_row   [N_SPR];
   logic [AW-1:0]       w_addr  [N_SPR];
   logic [N_SPR-1:0]    w_inbox;

   logic                r_s1_valid;
   logic [N_SPR-1:0]    r_s1_inbox;
   logic [AW-1:0]       r_s1_addr [N_SPR];

   logic [N_SPR-1:0]    w_mask;
   logic                w_hit;
   logic [IW-1:0]       w_id;
   logic                r_valid;
   logic                r_hit;
   logic [IW-1:0]       r_id;

   assign w_clr_last = (r_clr_spr == IW'(N_SPR - 1)) && (r_clr_addr == {AW{1'b1}});

   // FSM state register
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         r_state <= ST_CLEAR;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next state: leave CLEAR once the last mask bit is being zeroed, RUN is sticky
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_CLEAR: begin
            if (w_clr_last) begin
               w_state_nxt = ST_RUN;
            end else begin
               w_state_nxt = ST_CLEAR;
            end
         end
         ST_RUN:   w_state_nxt = ST_RUN;
         default:  w_state_nxt = ST_CLEAR;
      endcase
   end

   // FSM outputs: clear sweep enable and run qualifier
   always_comb begin
      w_clr_active = 1'b0;
      w_run        = 1'b0;
      case (r_state)
         ST_CLEAR: w_clr_active = 1'b1;
         ST_RUN:   w_run        = 1'b1;
         default: begin
            w_clr_active = 1'b0;
            w_run        = 1'b0;
         end
      endcase
   end

   // Clear sweep counter: walks {sprite, address} one bit per cycle
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         r_clr_spr  <= '0;
         r_clr_addr <= '0;
      end else if (w_clr_active) begin
         if (r_clr_addr == {AW{1'b1}}) begin
            r_clr_addr <= '0;
            r_clr_spr  <= r_clr_spr + IW'(1);
         end else begin
            r_clr_addr <= r_clr_addr + AW'(1);
         end
      end
   end

   // Ready flag registered from the next state so it rises together with RUN
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         r_ready <= 1'b0;
      end else begin
         r_ready <= (w_state_nxt == ST_RUN);
      end
   end

   // Host writes/loads are honoured only in RUN and only for existing sprites
   assign w_wr_ok  = w_run & bus.iWrEn  & ({1'b0, bus.iWrSprite}  < (IW + 1)'(N_SPR));
   assign w_pos_ok = w_run & bus.iPosEn & ({1'b0, bus.iPosSprite} < (IW + 1)'(N_SPR));

   // Mask write port select: clear sweep owns the port in CLEAR, host in RUN
   always_comb begin
      w_mem_we   = 1'b0;
      w_mem_spr  = '0;
      w_mem_addr = '0;
      w_mem_wd   = 1'b0;
      if (w_clr_active) begin
         w_mem_we   = 1'b1;
         w_mem_spr  = r_clr_spr;
         w_mem_addr = r_clr_addr;
         w_mem_wd   = 1'b0;
      end else if (w_wr_ok) begin
         w_mem_we   = 1'b1;
         w_mem_spr  = bus.iWrSprite;
         w_mem_addr = bus.iWrAddr;
         w_mem_wd   = bus.iWrData;
      end else begin
         w_mem_we   = 1'b0;
      end
   end

   // Mask storage; contents are defined by the clear sweep, not by reset
   always_ff @(posedge Clock) begin
      for (int s = 0; s < N_SPR; s++) begin
         if (w_mem_we && (w_mem_spr == IW'(s))) begin
            r_mem[s][w_mem_addr] <= w_mem_wd;
         end
      end
   end

   // Per-sprite position and flip registers
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         for (int s = 0; s < N_SPR; s++) begin
            r_pos_x[s] <= '0;
            r_pos_y[s] <= '0;
            r_flip[s]  <= 2'b00;
         end
      end else begin
         for (int s = 0; s < N_SPR; s++) begin
            if (w_pos_ok && (bus.iPosSprite == IW'(s))) begin
               r_pos_x[s] <= bus.iPosX;
               r_pos_y[s] <= bus.iPosY;
               r_flip[s]  <= bus.iPosFlip;
            end
         end
      end
   end

   // Stage 1 combinational: box test with one extra bit so off-screen parts never wrap
   always_comb begin
      w_inbox = '0;
      for (int s = 0; s < N_SPR; s++) begin
         w_dx[s]    = {1'b0, bus.iPixelX} - {1'b0, r_pos_x[s]};
         w_dy[s]    = {1'b0, bus.iPixelY} - {1'b0, r_pos_y[s]};
         w_inbox[s] = bus.iSprEnable[s]
                    & (bus.iPixelX >= r_pos_x[s]) & (w_dx[s] < DW'(SPR_W))
                    & (bus.iPixelY >= r_pos_y[s]) & (w_dy[s] < DW'(SPR_H));
         // Power-of-two sizes make SIZE-1-d the bitwise complement of d
         w_col[s]   = r_flip[s][0] ? ~w_dx[s][CB-1:0] : w_dx[s][CB-1:0];
         w_row[s]   = r_flip[s][1] ? ~w_dy[s][RB-1:0] : w_dy[s][RB-1:0];
         w_addr[s]  = {w_row[s], w_col[s]};
      end
   end

   // Stage 1 registers; pixels arriving outside RUN are dropped here
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         r_s1_valid <= 1'b0;
         r_s1_inbox <= '0;
         for (int s = 0; s < N_SPR; s++) begin
            r_s1_addr[s] <= '0;
         end
      end else begin
         r_s1_valid <= w_run & bus.iPixelValid;
         r_s1_inbox <= w_inbox & {N_SPR{w_run & bus.iPixelValid}};
         for (int s = 0; s < N_SPR; s++) begin
            r_s1_addr[s] <= w_addr[s];
         end
      end
   end

   // Stage 2 combinational: mask lookup (read-before-write) and lowest-index priority
   always_comb begin
      w_mask = '0;
      w_hit  = 1'b0;
      w_id   = '0;
      for (int s = 0; s < N_SPR; s++) begin
         w_mask[s] = r_mem[s][r_s1_addr[s]] & r_s1_inbox[s];
      end
      for (int s = N_SPR - 1; s >= 0; s--) begin
         if (w_mask[s]) begin
            w_hit = 1'b1;
            w_id  = IW'(s);
         end else begin
            w_hit = w_hit;
            w_id  = w_id;
         end
      end
   end

   // Stage 2 output registers; hit and id are forced low for empty slots
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         r_valid <= 1'b0;
         r_hit   <= 1'b0;
         r_id    <= '0;
      end else begin
         r_valid <= r_s1_valid;
         r_hit   <= r_s1_valid & w_hit;
         r_id    <= (r_s1_valid & w_hit) ? w_id : '0;
      end
   end

   assign bus.oReady = r_ready;
   assign bus.oValid = r_valid;
   assign bus.oHit   = r_hit;
   assign bus.oSprId = r_id;

endmodule

// File: tb/tb_sprite_mask_engine.sv
// Scoreboard bench for sprite_mask_engine: a behavioural model predicts each pixel
// result when the pixel reaches stage 2; the monitor compares DUT outputs in order.
module tb_sprite_mask_engine;
   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_pass = 0;

   sprite_mask_engine_if bus_if ();

   sprite_mask_engine dut (
      .Clock (clk),
      .Reset (rst_n),
      .bus   (bus_if)
   );

   always #5 clk = ~clk;

   // Edge counter used for latency checks
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit hit;
      int id;
      int cyc;
   } exp_t;
   exp_t sb[$];

   // Behavioural model state
   bit       m_run = 1'b0;
   bit       m_mem [4][256];
   int       m_px [4];
   int       m_py [4];
   bit [1:0] m_flip [4];
   bit       m_s1_valid = 1'b0;
   bit       m_s1_in [4];
   int       m_s1_addr [4];
   int       m_s1_cyc;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs === exp_v) n_pass++;
      else $display("FAIL %s: observed %0h required %0h (t=%0t)", tag, obs, exp_v, $time);
   endtask

   task automatic model_reset();
      sb.delete();
      m_run = 1'b0;
      m_s1_valid = 1'b0;
      for (int s = 0; s < 4; s++) begin
         m_px[s] = 0;
         m_py[s] = 0;
         m_flip[s] = 2'b00;
         for (int a = 0; a < 256; a++) m_mem[s][a] = 1'b0;
      end
   endtask

   // One cycle: resolve model stage 2, capture stage 1, apply writes, advance to next negedge
   task automatic tick();
      exp_t e;
      int dx, dy, col, row;
      if (m_s1_valid) begin
         e.hit = 1'b0;
         e.id  = 0;
         e.cyc = m_s1_cyc;
         for (int s = 3; s >= 0; s--) begin
            if (m_s1_in[s] && m_mem[s][m_s1_addr[s]]) begin
               e.hit = 1'b1;
               e.id  = s;
            end
         end
         sb.push_back(e);
      end
      m_s1_valid = m_run && (bus_if.iPixelValid === 1'b1);
      m_s1_cyc   = cyc;
      for (int s = 0; s < 4; s++) begin
         dx = int'(bus_if.iPixelX) - m_px[s];
         dy = int'(bus_if.iPixelY) - m_py[s];
         m_s1_in[s] = m_s1_valid && bus_if.iSprEnable[s] && dx >= 0 && dx < 16 && dy >= 0 && dy < 16;
         col = m_flip[s][0] ? 15 - dx : dx;
         row = m_flip[s][1] ? 15 - dy : dy;
         m_s1_addr[s] = m_s1_in[s] ? row * 16 + col : 0;
      end
      if (m_run && bus_if.iWrEn) m_mem[bus_if.iWrSprite][bus_if.iWrAddr] = bus_if.iWrData;
      if (m_run && bus_if.iPosEn) begin
         m_px[bus_if.iPosSprite]   = int'(bus_if.iPosX);
         m_py[bus_if.iPosSprite]   = int'(bus_if.iPosY);
         m_flip[bus_if.iPosSprite] = bus_if.iPosFlip;
      end
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic pixel(input int x, input int y);
      bus_if.iPixelX = 10'(x);
      bus_if.iPixelY = 10'(y);
      bus_if.iPixelValid = 1'b1;
      tick();
      bus_if.iPixelValid = 1'b0;
   endtask

   task automatic wr_bit(input int spr, input int addr, input bit d);
      bus_if.iWrEn = 1'b1;
      bus_if.iWrSprite = 2'(spr);
      bus_if.iWrAddr = 8'(addr);
      bus_if.iWrData = d;
      tick();
      bus_if.iWrEn = 1'b0;
   endtask

   task automatic load_pos(input int spr, input int x, input int y, input bit [1:0] flip);
      bus_if.iPosEn = 1'b1;
      bus_if.iPosSprite = 2'(spr);
      bus_if.iPosX = 10'(x);
      bus_if.iPosY = 10'(y);
      bus_if.iPosFlip = flip;
      tick();
      bus_if.iPosEn = 1'b0;
   endtask

   // Bounded wait for the clear sweep; counts edges from reset release to oReady
   task automatic wait_ready();
      int n;
      n = 0;
      while (n < 3000) begin
         @(posedge clk);
         #1;
         n++;
         if (bus_if.oReady === 1'b1) break;
      end
      bus_if.iPixelValid = 1'b0;
      bus_if.iWrEn = 1'b0;
      bus_if.iPosEn = 1'b0;
      check_eq("clear_cycles", n, 1024);
      m_run = 1'b1;
      m_s1_valid = 1'b0;
      @(negedge clk);
   endtask

   // Output monitor: pop expected result on every valid, require zeros otherwise
   always begin
      exp_t e;
      @(posedge clk);
      #1;
      if (bus_if.oValid === 1'b1) begin
         if (sb.size() == 0) begin
            check_eq("spurious_valid", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            check_eq("hit", bus_if.oHit, e.hit);
            check_eq("spr_id", bus_if.oSprId, e.id);
            check_eq("latency", cyc - e.cyc, 2);
         end
      end else begin
         check_eq("idle_out", {bus_if.oHit, bus_if.oSprId}, 0);
      end
   end

   // Watchdog so the run always ends
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bus_if.iWrEn = 1'b0;      bus_if.iWrSprite = 2'd0;  bus_if.iWrAddr = 8'd0;
      bus_if.iWrData = 1'b0;    bus_if.iPosEn = 1'b0;     bus_if.iPosSprite = 2'd0;
      bus_if.iPosX = 10'd0;     bus_if.iPosY = 10'd0;     bus_if.iPosFlip = 2'b00;
      bus_if.iSprEnable = 4'b0; bus_if.iPixelX = 10'd0;   bus_if.iPixelY = 10'd0;
      bus_if.iPixelValid = 1'b0;
      model_reset();
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst_ready", bus_if.oReady, 0);
      check_eq("rst_valid", bus_if.oValid, 0);
      check_eq("rst_hit", bus_if.oHit, 0);
      check_eq("rst_id", bus_if.oSprId, 0);

      // 1: clear sweep length (pixels offered during CLEAR must be ignored), then empty sweep
      bus_if.iPixelValid = 1'b1;
      rst_n = 1'b1;
      wait_ready();
      bus_if.iSprEnable = 4'b1111;
      for (int y = 0; y < 18; y++) begin
         for (int x = 0; x < 18; x++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            pixel(x, y);
         end
      end
      idle(3);

      // 2: sprite 0 corner pattern at (100,50)
      for (int a = 0; a < 256; a++) begin
         if (((a / 16) < 3 || (a / 16) > 12) && ((a % 16) < 3 || (a % 16) > 12)) wr_bit(0, a, 1'b1);
      end
      load_pos(0, 100, 50, 2'b00);
      bus_if.iSprEnable = 4'b0001;
      pixel(100, 50);
      pixel(103, 50);
      pixel(116, 50);
      pixel(99, 50);
      pixel(115, 65);
      pixel(101, 52);
      idle(3);

      // 3: overlapping full masks on sprites 0 and 2
      for (int a = 0; a < 256; a++) begin
         wr_bit(0, a, 1'b1);
         wr_bit(2, a, 1'b1);
      end
      load_pos(0, 10, 10, 2'b00);
      load_pos(2, 10, 10, 2'b00);
      bus_if.iSprEnable = 4'b0101;
      pixel(12, 12);
      bus_if.iSprEnable = 4'b0100;
      pixel(12, 12);
      pixel(26, 10);
      idle(3);

      // 4: flips on sprite 1, single bit at row 0 col 0
      wr_bit(1, 0, 1'b1);
      bus_if.iSprEnable = 4'b0010;
      load_pos(1, 0, 0, 2'b01);
      pixel(15, 0);
      pixel(0, 0);
      load_pos(1, 0, 0, 2'b11);
      pixel(15, 15);
      pixel(0, 0);
      pixel(15, 0);
      idle(3);

      // 5: right-edge sprite without wrap, then read-before-write
      wr_bit(3, 3, 1'b1);
      wr_bit(3, 4, 1'b1);
      load_pos(3, 1020, 0, 2'b00);
      bus_if.iSprEnable = 4'b1000;
      pixel(1023, 0);
      pixel(0, 0);
      pixel(1019, 0);
      pixel(1023, 0);
      bus_if.iPixelX = 10'd1023; bus_if.iPixelY = 10'd0; bus_if.iPixelValid = 1'b1;
      bus_if.iWrEn = 1'b1; bus_if.iWrSprite = 2'd3; bus_if.iWrAddr = 8'd3; bus_if.iWrData = 1'b0;
      tick();
      bus_if.iWrEn = 1'b0;
      pixel(1023, 0);
      idle(3);

      // 6: reset with a full pipeline and active strobes
      bus_if.iSprEnable = 4'b1111;
      bus_if.iPixelX = 10'd1023; bus_if.iPixelY = 10'd0; bus_if.iPixelValid = 1'b1;
      bus_if.iWrEn = 1'b1; bus_if.iWrSprite = 2'd0; bus_if.iWrAddr = 8'd0; bus_if.iWrData = 1'b1;
      bus_if.iPosEn = 1'b1; bus_if.iPosSprite = 2'd0; bus_if.iPosX = 10'd5; bus_if.iPosY = 10'd5;
      bus_if.iPosFlip = 2'b00;
      tick();
      tick();
      check_eq("pre_rst_valid", bus_if.oValid, 1);
      rst_n = 1'b0;
      model_reset();
      #1;
      check_eq("mid_rst_valid", bus_if.oValid, 0);
      check_eq("mid_rst_ready", bus_if.oReady, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      wait_ready();
      for (int y = 0; y < 16; y++) begin
         for (int x = 0; x < 16; x++) pixel(x, y);
      end
      idle(4);
      check_eq("sb_drain", sb.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
